// File: rtl/sdf_query_scheduler_if.sv
// sdf_query_scheduler_if
//   Bundles the requester-side and SDF-unit-side signals of the query
//   scheduler.
//   slave  : scheduler view. It takes requests and the SDF distance, and
//            drives grants, results and the query point.
//   master : environment view (march controllers plus the SDF unit).
//   Signals:
//     req_valid_in / req_point_in / req_ready_out : per-requester query request.
//     res_valid_out / res_sdf_out / res_ready_in  : per-requester result.
//     query_point_out / query_sdf_in              : to/from the SDF unit.
interface sdf_query_scheduler_if #(
    parameter int NUM_REQ  = 4,
    parameter int FP_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid_in;
    logic [NUM_REQ*3*FP_WIDTH-1:0] req_point_in;
    logic [NUM_REQ-1:0]            req_ready_out;
    logic [NUM_REQ-1:0]            res_valid_out;
    logic [NUM_REQ*FP_WIDTH-1:0]   res_sdf_out;
    logic [NUM_REQ-1:0]            res_ready_in;
    logic [3*FP_WIDTH-1:0]         query_point_out;
    logic [FP_WIDTH-1:0]           query_sdf_in;

    modport slave (
        input  req_valid_in, req_point_in, res_ready_in, query_sdf_in,
        output req_ready_out, res_valid_out, res_sdf_out, query_point_out
    );

    modport master (
        output req_valid_in, req_point_in, res_ready_in, query_sdf_in,
        input  req_ready_out, res_valid_out, res_sdf_out, query_point_out
    );
endinterface

// File: rtl/sdf_query_scheduler.sv
// sdf_query_scheduler
//   Shares one fixed-latency, fully pipelined SDF query unit between NUM_REQ
//   ray-marcher requesters.
//   - A round-robin arbiter issues at most one point per cycle.
//   - A requester-ID tag pipeline follows each query through the unit.
//   - Each returned distance is routed into the owner's result register.
//   Ports:
//     clk_in, rst_n_in : clock and asynchronous active-low reset.
//     bus (slave)      : request/result handshakes plus the SDF point/distance.
//     busy_out         : any query pending or any result not yet consumed.
module sdf_query_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int LATENCY  = 4,
    parameter int FP_WIDTH = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    sdf_query_scheduler_if.slave   bus,
    output logic                   busy_out
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = 3 * FP_WIDTH;

    logic [NUM_REQ-1:0]          pending, res_valid, eligible, grant;
    logic [NUM_REQ-1:0]          capture, consume, pending_nxt, res_valid_nxt;
    logic [IDW-1:0]              rr_ptr, grant_id;
    logic                        grant_any;
    logic [LATENCY:0]            vld_pipe;
    logic [IDW-1:0]              id_pipe [LATENCY+1];
    logic [NUM_REQ*FP_WIDTH-1:0] res_sdf;
    logic [PW-1:0]               query_point;

    // A requester has at most one query in flight or held.
    assign eligible = bus.req_valid_in & ~pending & ~res_valid;

    // Round-robin search: first eligible index at or above rr_ptr, with wrap-around.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    // Ready is gated by reset so that it reads zero while reset is held.
    assign grant = (grant_any && rst_n_in) ? (NUM_REQ'(1) << grant_id) : '0;

    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            capture[j] = vld_pipe[LATENCY] && (id_pipe[LATENCY] == IDW'(j));
        end
    end

    assign consume       = res_valid & bus.res_ready_in;
    assign pending_nxt   = (pending & ~capture) | grant;
    assign res_valid_nxt = (res_valid & ~consume) | capture;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pending     <= '0;
            res_valid   <= '0;
            res_sdf     <= '0;
            query_point <= '0;
            busy_out    <= 1'b0;
            rr_ptr      <= '0;
            vld_pipe    <= '0;
            for (int k = 0; k <= LATENCY; k++) id_pipe[k] <= '0;
        end else begin
            pending   <= pending_nxt;
            res_valid <= res_valid_nxt;
            busy_out  <= (|pending_nxt) | (|res_valid_nxt);
            // Stage 0 carries the grant of this edge; stage LATENCY lines up with query_sdf_in.
            vld_pipe  <= {vld_pipe[LATENCY-1:0], grant_any};
            id_pipe[0] <= grant_id;
            for (int k = 1; k <= LATENCY; k++) id_pipe[k] <= id_pipe[k-1];
            if (grant_any) begin
                query_point <= bus.req_point_in[int'(grant_id)*PW +: PW];
                rr_ptr      <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (capture[j]) res_sdf[j*FP_WIDTH +: FP_WIDTH] <= bus.query_sdf_in;
            end
        end
    end

    assign bus.req_ready_out   = grant;
    assign bus.res_valid_out   = res_valid;
    assign bus.res_sdf_out     = res_sdf;
    assign bus.query_point_out = query_point;
endmodule

// File: tb/tb_sdf_query_scheduler.sv
// tb_sdf_query_scheduler
//   Runs two scheduler instances in lockstep:
//     DUT A: NUM_REQ=4, LATENCY=4.
//     DUT B: NUM_REQ=2, LATENCY=1.
//   Each instance has a delay-line SDF stub that returns point.x.
//   A per-requester reference model keeps pending/held flags and the
//   due-edge of each query. It predicts grants, results, busy and the query
//   point every cycle.
module tb_sdf_query_scheduler;
    localparam int NA = 4, LA = 4, NB = 2, LB = 1, FPW = 32, PW = 96;

    logic clk = 1'b0, rst_n = 1'b0;
    logic busy_a, busy_b;
    int   cyc = 0, n_cmp = 0, n_err = 0;

    sdf_query_scheduler_if #(.NUM_REQ(NA), .FP_WIDTH(FPW)) ifa ();
    sdf_query_scheduler_if #(.NUM_REQ(NB), .FP_WIDTH(FPW)) ifb ();

    sdf_query_scheduler #(.NUM_REQ(NA), .LATENCY(LA), .FP_WIDTH(FPW)) u_dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .bus(ifa.slave), .busy_out(busy_a));
    sdf_query_scheduler #(.NUM_REQ(NB), .LATENCY(LB), .FP_WIDTH(FPW)) u_dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .bus(ifb.slave), .busy_out(busy_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SDF stubs: distance = point.x, LATENCY edges after the point changes.
    logic [FPW-1:0] sa [LA];
    logic [FPW-1:0] sb;
    always @(posedge clk) begin
        sa[0] <= ifa.query_point_out[PW-1 -: FPW];
        for (int k = 1; k < LA; k++) sa[k] <= sa[k-1];
        sb <= ifb.query_point_out[PW-1 -: FPW];
    end
    assign ifa.query_sdf_in = sa[LA-1];
    assign ifb.query_sdf_in = sb;

    // Stimulus and observation, widened to a common shape per DUT index.
    logic [15:0]    s_valid [2];
    logic [15:0]    s_rres  [2];
    logic [PW-1:0]  s_pt    [2][16];
    logic [15:0]    o_ready [2];
    logic [15:0]    o_rv    [2];
    logic           o_busy  [2];
    logic [PW-1:0]  o_qp    [2];
    logic [FPW-1:0] o_sdf   [2][16];

    assign ifa.req_valid_in = s_valid[0][NA-1:0];
    assign ifa.res_ready_in = s_rres[0][NA-1:0];
    assign ifb.req_valid_in = s_valid[1][NB-1:0];
    assign ifb.res_ready_in = s_rres[1][NB-1:0];
    assign o_ready[0] = 16'(ifa.req_ready_out);
    assign o_ready[1] = 16'(ifb.req_ready_out);
    assign o_rv[0]    = 16'(ifa.res_valid_out);
    assign o_rv[1]    = 16'(ifb.res_valid_out);
    assign o_busy[0]  = busy_a;
    assign o_busy[1]  = busy_b;
    assign o_qp[0]    = ifa.query_point_out;
    assign o_qp[1]    = ifb.query_point_out;

    for (genvar i = 0; i < 16; i++) begin : g_map
        if (i < NA) begin : g_a
            assign ifa.req_point_in[i*PW +: PW] = s_pt[0][i];
            assign o_sdf[0][i] = ifa.res_sdf_out[i*FPW +: FPW];
        end else begin : g_a0
            assign o_sdf[0][i] = '0;
        end
        if (i < NB) begin : g_b
            assign ifb.req_point_in[i*PW +: PW] = s_pt[1][i];
            assign o_sdf[1][i] = ifb.res_sdf_out[i*FPW +: FPW];
        end else begin : g_b0
            assign o_sdf[1][i] = '0;
        end
    end

    // Reference model state.
    bit             m_pend [2][16];
    bit             m_rv   [2][16];
    int             m_due  [2][16];
    logic [FPW-1:0] m_x    [2][16];
    logic [FPW-1:0] m_sdf  [2][16];
    logic [PW-1:0]  m_qp   [2];
    int             m_rr   [2];

    function automatic int nreq(int d); return (d == 0) ? NA : NB; endfunction
    function automatic int lat(int d);  return (d == 0) ? LA : LB; endfunction

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s at edge %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset(int d);
        for (int i = 0; i < 16; i++) begin
            m_pend[d][i] = 0; m_rv[d][i] = 0; m_due[d][i] = 0;
            m_x[d][i] = '0;   m_sdf[d][i] = '0;
        end
        m_qp[d] = '0;
        m_rr[d] = 0;
    endtask

    // First free, requesting index, searching upward from the round-robin pointer.
    function automatic int mgrant(int d);
        int i;
        if (rst_n !== 1'b1) return -1;
        for (int k = 0; k < nreq(d); k++) begin
            i = (m_rr[d] + k) % nreq(d);
            if (s_valid[d][i] === 1'b1 && !m_pend[d][i] && !m_rv[d][i]) return i;
        end
        return -1;
    endfunction

    task automatic check_outputs(int d);
        int g;
        logic [15:0] er, erv;
        logic eb;
        g   = mgrant(d);
        er  = (g >= 0) ? (16'd1 << g) : 16'd0;
        erv = '0;
        eb  = 1'b0;
        for (int i = 0; i < nreq(d); i++) begin
            erv[i] = m_rv[d][i];
            eb = eb | m_pend[d][i] | m_rv[d][i];
        end
        chk($sformatf("d%0d_ready", d), PW'(o_ready[d]), PW'(er));
        chk($sformatf("d%0d_res_valid", d), PW'(o_rv[d]), PW'(erv));
        chk($sformatf("d%0d_busy", d), PW'(o_busy[d]), PW'(eb));
        chk($sformatf("d%0d_query_point", d), o_qp[d], m_qp[d]);
        for (int i = 0; i < nreq(d); i++)
            chk($sformatf("d%0d_res_sdf%0d", d, i), PW'(o_sdf[d][i]), PW'(m_sdf[d][i]));
    endtask

    // Apply the rules for the upcoming edge; the grant uses the pre-edge state.
    task automatic advance(int d);
        int g, e;
        e = cyc + 1;
        g = mgrant(d);
        for (int i = 0; i < nreq(d); i++) begin
            if (m_rv[d][i] && s_rres[d][i] === 1'b1) m_rv[d][i] = 0;
            if (m_pend[d][i] && m_due[d][i] == e) begin
                m_pend[d][i] = 0;
                m_rv[d][i]   = 1;
                m_sdf[d][i]  = m_x[d][i];
            end
        end
        if (g >= 0) begin
            m_pend[d][g] = 1;
            m_due[d][g]  = e + lat(d) + 1;
            m_x[d][g]    = s_pt[d][g][PW-1 -: FPW];
            m_qp[d]      = s_pt[d][g];
            m_rr[d]      = (g + 1) % nreq(d);
        end
    endtask

    task automatic rand_in(int d);
        for (int i = 0; i < nreq(d); i++) begin
            s_valid[d][i] = ($urandom_range(0, 3) != 0);
            s_rres[d][i]  = ($urandom_range(0, 2) != 0);
            s_pt[d][i]    = {$urandom, $urandom, $urandom};
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_outputs(d);
            advance(d);
        end
        @(posedge clk);
        #1;
        rand_in(1);
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_outputs(0);
        check_outputs(1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rand_in(1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = '0;
            s_rres[d] = '0;
            for (int i = 0; i < 16; i++) s_pt[d][i] = '0;
        end
        s_valid[0] = 16'h000F;
        #3;
        model_reset(0);
        model_reset(1);
        check_outputs(0);
        check_outputs(1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        s_valid[0] = '0;
        rand_in(1);

        // Single request from requester 0, result held, then consumed.
        s_pt[0][0] = {32'h0001_8000, $urandom, $urandom};
        s_valid[0] = 16'h0001;
        tick();
        s_valid[0] = '0;
        run(8);
        chk("single_valid", PW'(o_rv[0][0]), PW'(1'b1));
        chk("single_sdf", PW'(o_sdf[0][0]), PW'(32'h0001_8000));
        s_rres[0] = 16'h000F;
        run(2);

        // All requesters streaming with results consumed at once.
        for (int i = 0; i < NA; i++) s_pt[0][i] = {32'h1000_0000 + i, $urandom, $urandom};
        s_valid[0] = 16'h000F;
        run(30);

        // Requester 1 result held back for 20 cycles.
        s_rres[0] = 16'h000D;
        run(20);
        s_rres[0] = 16'h000F;
        s_valid[0] = '0;
        run(10);

        // Move the pointer to 2, then requesters 0 and 3 compete: 3 wins first.
        s_valid[0] = 16'h0002;
        tick();
        s_valid[0] = '0;
        run(8);
        s_valid[0] = 16'h0009;
        #1 chk("rr_first", PW'(o_ready[0]), PW'(16'h0008));
        tick();
        #1 chk("rr_second", PW'(o_ready[0]), PW'(16'h0001));
        run(10);

        // Reset with queries in flight; nothing may surface afterwards.
        s_valid[0] = '0;
        run(8);
        s_valid[0] = 16'h000F;
        run(3);
        do_reset();
        s_valid[0] = '0;
        run(10);
        chk("post_reset_busy", PW'(o_busy[0]), PW'(1'b0));

        // Randomized traffic on both instances.
        for (int k = 0; k < 400; k++) begin
            rand_in(0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sdf_query_scheduler.md
Name: sdf_query_scheduler

Overview:
- Shares one fixed-latency, fully pipelined SDF query unit (e.g. the 4-cycle infinite-sponge query) between NUM_REQ ray-marcher requesters.
- Arbitrates requests round-robin and issues at most one query point per cycle to the SDF unit.
- Tracks in-flight queries with a requester-ID tag pipeline that matches the unit's latency, and routes each returned distance to the owning requester's result buffer.
- Sits between the per-pixel march controllers and the SDF query module; the SDF module itself has no handshake.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- LATENCY, 4: SDF unit latency in clock edges from query_point_out change to matching query_sdf_in (1..8).
- FP_WIDTH, 32: width of one fp scalar; a vec3 is 3*FP_WIDTH, packed {x,y,z} with x in the MSBs.

Ports:
- clk_in, input, 1: clock.
- rst_n_in, input, 1: asynchronous active-low reset.
- req_valid_in, input, NUM_REQ: per-requester query request.
- req_point_in, input, NUM_REQ*3*FP_WIDTH: per-requester query point; requester i occupies slice i.
- req_ready_out, output, NUM_REQ: request accepted this cycle when valid&ready.
- res_valid_out, output, NUM_REQ: per-requester result held.
- res_sdf_out, output, NUM_REQ*FP_WIDTH: per-requester distance; requester i occupies slice i.
- res_ready_in, input, NUM_REQ: requester consumes the result.
- query_point_out, output, 3*FP_WIDTH: point to the SDF unit (registered).
- query_sdf_in, input, FP_WIDTH: distance from the SDF unit.
- busy_out, output, 1: any query pending or any result unconsumed.

Behaviour:
- Reset: asynchronous, takes effect immediately on rst_n_in low.
  - Clears req_ready_out, res_valid_out, res_sdf_out, query_point_out, busy_out, all tags, all pending bits, and rr_ptr (to 0).
- Eligibility: requester i is eligible when req_valid_in[i] & ~pending[i] & ~res_valid_out[i]. Each requester has at most one query outstanding.
- Grant:
  - Combinational; picks the first eligible requester searching from rr_ptr upward with wrap-around.
  - req_ready_out is one-hot or zero and high only for the granted requester. ready may depend on valid.
- On a handshake edge for requester g:
  - query_point_out <= req_point_in[g].
  - tag[0] <= {1, g}.
  - pending[g] <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- No handshake: rr_ptr holds, tag[0] <= {0, x}, and query_point_out holds its value (don't-care to the SDF unit).
- Tag pipeline: tag[k+1] <= tag[k] every edge, depth LATENCY+1. Tag stage LATENCY is aligned with query_sdf_in.
- Capture: when tag[LATENCY] is valid with id j, on that edge:
  - res_sdf_out[j] <= query_sdf_in.
  - res_valid_out[j] <= 1.
  - pending[j] <= 0.
- Request-to-result latency is exactly LATENCY+1 edges after the handshake edge. Throughput is one query per cycle aggregate.
- Result handshake: res_valid_out[i] & res_ready_in[i] clears res_valid_out[i] on that edge. res_sdf_out[i] holds its last value.
  - A new request from i is eligible only from the following cycle.
- Simultaneous events:
  - Capture for j and result consumption for a different i in the same cycle are independent.
  - Capture and consumption for the same i cannot coincide, because pending and res_valid are exclusive.
- Requester dropping req_valid_in before the handshake: no effect and no state change.
- Reset mid-operation: in-flight tags are discarded. SDF outputs for those queries arrive with invalid tags and are ignored.
- busy_out = |pending | |res_valid_out, registered in the same edge as its sources.
- Width rule: distances and points pass through unmodified; no arithmetic on fp values.

Test Plan:
- Single request: NUM_REQ=4, LATENCY=4, with a stub SDF returning point.x delayed 4 edges.
  - Req0 point x=32'h0001_8000 handshakes at edge 10 → res_valid_out[0] rises after edge 15 with res_sdf_out[0]=32'h0001_8000.
  - req_ready_out[0] stays low for edges 11–15.
- All four requesters valid continuously with res_ready_in=1:
  - Grants go in order 0,1,2,3 on consecutive edges.
  - Each result returns 5 edges after its own grant, carrying the correct point.x.
  - Re-grant 0 occurs at the earliest cycle after its result is consumed.
- Backpressure: req1 result held with res_ready_in[1]=0 for 20 cycles.
  - res_valid_out[1] and its value are stable; req1 gets no grant.
  - Other requesters keep being served round-robin (0,2,3,...).
- Round-robin fairness: rr_ptr=2 with req0 and req3 valid → req3 granted first, then req0.
- Reset mid-flight: assert rst_n_in low for 1 cycle while 3 queries are in flight.
  - All outputs are 0 immediately.
  - No res_valid_out pulses in the next 10 cycles; busy_out=0.
- LATENCY=1 with NUM_REQ=2 and back-to-back requests: every result appears exactly 2 edges after its handshake, with no ID mix-up.
